// File: rtl/hsem_lock.sv
// Hardware semaphore block shared by two cores.
// Each core issues lock/unlock requests against an indexed semaphore and gets a
// registered response one cycle later. A core that finds a semaphore busy is
// marked pending and is notified when the owner releases it.
// Ports:
//   hclk, hreset                 clock, asynchronous active-high reset
//   req_x, cmd_x, sem_id_x       request strobe, 1=lock/0=unlock, semaphore index
//   resp_vld_x, resp_ok_x        one-cycle response strobe and success flag
//   semerr_x                     error code, valid only with resp_vld_x
//   notify_x                     one-cycle pulse: awaited semaphore was released
//   lock_stat, owner_stat        per-semaphore locked flag and owning core
module hsem_lock #(
    parameter int unsigned SEM_NUM = 8,
    parameter int unsigned ID_W    = 4
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               req_0,
    input  logic               cmd_0,
    input  logic [ID_W-1:0]    sem_id_0,
    input  logic               req_1,
    input  logic               cmd_1,
    input  logic [ID_W-1:0]    sem_id_1,
    output logic               resp_vld_0,
    output logic               resp_ok_0,
    output logic [31:0]        semerr_0,
    output logic               notify_0,
    output logic               resp_vld_1,
    output logic               resp_ok_1,
    output logic [31:0]        semerr_1,
    output logic               notify_1,
    output logic [SEM_NUM-1:0] lock_stat,
    output logic [SEM_NUM-1:0] owner_stat
);

    localparam int unsigned IDX_N     = 1 << ID_W;
    localparam logic [31:0] ERR_NONE  = 32'h0;
    localparam logic [31:0] ERR_OWN   = 32'h1;
    localparam logic [31:0] ERR_FREE  = 32'h2;
    localparam logic [31:0] ERR_OTHER = 32'h4;
    localparam logic [31:0] ERR_RANGE = 32'h8;

    logic [SEM_NUM-1:0] locked_q, owner_q, pend0_q, pend1_q;
    logic [SEM_NUM-1:0] locked_d, owner_d, pend0_d, pend1_d;
    logic               rr_q, rr_d;

    // State widened to the full index space so any sem_id can be looked up safely.
    logic [IDX_N-1:0] locked_p, owner_p, pend0_p, pend1_p;
    assign locked_p = IDX_N'(locked_q);
    assign owner_p  = IDX_N'(owner_q);
    assign pend0_p  = IDX_N'(pend0_q);
    assign pend1_p  = IDX_N'(pend1_q);

    logic valid_0, valid_1, lk_0, lk_1, ul_0, ul_1, same_id, contend;
    logic free_0, free_1, mine_0, mine_1, theirs_0, theirs_1;
    logic grant_0, grant_1, busy_0, busy_1, rel_0, rel_1;
    logic notify_0_c, notify_1_c;
    logic [31:0] err_0_c, err_1_c;

    // Request decode, evaluated against state at the start of the cycle.
    always_comb begin
        valid_0  = sem_id_0 < ID_W'(SEM_NUM);
        valid_1  = sem_id_1 < ID_W'(SEM_NUM);
        lk_0     = req_0 & cmd_0 & valid_0;
        lk_1     = req_1 & cmd_1 & valid_1;
        ul_0     = req_0 & ~cmd_0 & valid_0;
        ul_1     = req_1 & ~cmd_1 & valid_1;
        same_id  = sem_id_0 == sem_id_1;
        free_0   = ~locked_p[sem_id_0];
        free_1   = ~locked_p[sem_id_1];
        mine_0   = locked_p[sem_id_0] & ~owner_p[sem_id_0];
        theirs_0 = locked_p[sem_id_0] &  owner_p[sem_id_0];
        mine_1   = locked_p[sem_id_1] &  owner_p[sem_id_1];
        theirs_1 = locked_p[sem_id_1] & ~owner_p[sem_id_1];
        // Both cores grabbing the same free semaphore: rr picks the winner.
        contend  = lk_0 & lk_1 & same_id & free_0;
        grant_0  = lk_0 & free_0 & ~(contend &  rr_q);
        grant_1  = lk_1 & free_1 & ~(contend & ~rr_q);
        busy_0   = lk_0 & ~mine_0 & ~grant_0;
        busy_1   = lk_1 & ~mine_1 & ~grant_1;
        rel_0    = ul_0 & mine_0;
        rel_1    = ul_1 & mine_1;
        // A waiter becoming pending in this same cycle is notified immediately.
        notify_1_c = rel_0 & (pend1_p[sem_id_0] | (busy_1 & same_id));
        notify_0_c = rel_1 & (pend0_p[sem_id_1] | (busy_0 & same_id));

        err_0_c = ERR_NONE;
        if (req_0) begin
            if (!valid_0)                err_0_c = ERR_RANGE;
            else if (lk_0 && mine_0)     err_0_c = ERR_OWN;
            else if (ul_0 && free_0)     err_0_c = ERR_FREE;
            else if (ul_0 && theirs_0)   err_0_c = ERR_OTHER;
        end
        err_1_c = ERR_NONE;
        if (req_1) begin
            if (!valid_1)                err_1_c = ERR_RANGE;
            else if (lk_1 && mine_1)     err_1_c = ERR_OWN;
            else if (ul_1 && free_1)     err_1_c = ERR_FREE;
            else if (ul_1 && theirs_1)   err_1_c = ERR_OTHER;
        end
    end

    // Per-semaphore next state; a release clears a pending bit set in the same cycle.
    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        rr_d     = contend ? ~rr_q : rr_q;
        for (int unsigned n = 0; n < SEM_NUM; n++) begin
            if (busy_0 && sem_id_0 == ID_W'(n)) pend0_d[n] = 1'b1;
            if (busy_1 && sem_id_1 == ID_W'(n)) pend1_d[n] = 1'b1;
            if ((rel_0 && sem_id_0 == ID_W'(n)) || (rel_1 && sem_id_1 == ID_W'(n))) begin
                locked_d[n] = 1'b0;
                owner_d[n]  = 1'b0;
                pend0_d[n]  = 1'b0;
                pend1_d[n]  = 1'b0;
            end
            if (grant_0 && sem_id_0 == ID_W'(n)) begin
                locked_d[n] = 1'b1;
                owner_d[n]  = 1'b0;
                pend0_d[n]  = 1'b0;
            end
            if (grant_1 && sem_id_1 == ID_W'(n)) begin
                locked_d[n] = 1'b1;
                owner_d[n]  = 1'b1;
                pend1_d[n]  = 1'b0;
            end
        end
    end

    // Semaphore state and registered responses.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            locked_q   <= '0;
            owner_q    <= '0;
            pend0_q    <= '0;
            pend1_q    <= '0;
            rr_q       <= 1'b0;
            resp_vld_0 <= 1'b0;
            resp_ok_0  <= 1'b0;
            semerr_0   <= 32'h0;
            notify_0   <= 1'b0;
            resp_vld_1 <= 1'b0;
            resp_ok_1  <= 1'b0;
            semerr_1   <= 32'h0;
            notify_1   <= 1'b0;
        end else begin
            locked_q   <= locked_d;
            owner_q    <= owner_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            rr_q       <= rr_d;
            resp_vld_0 <= req_0;
            resp_ok_0  <= grant_0 | rel_0;
            semerr_0   <= err_0_c;
            notify_0   <= notify_0_c;
            resp_vld_1 <= req_1;
            resp_ok_1  <= grant_1 | rel_1;
            semerr_1   <= err_1_c;
            notify_1   <= notify_1_c;
        end
    end

    assign lock_stat  = locked_q;
    assign owner_stat = owner_q;

endmodule

// File: tb/tb_hsem_lock.sv
// Directed bench for hsem_lock with hand-computed expected values.
module tb_hsem_lock;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        req_0, cmd_0, req_1, cmd_1;
    logic [3:0]  sem_id_0, sem_id_1;
    logic        resp_vld_0, resp_ok_0, notify_0;
    logic        resp_vld_1, resp_ok_1, notify_1;
    logic [31:0] semerr_0, semerr_1;
    logic [7:0]  lock_stat, owner_stat;

    int checks = 0;
    int errors = 0;

    hsem_lock #(.SEM_NUM(8), .ID_W(4)) dut (
        .hclk(hclk), .hreset(hreset),
        .req_0(req_0), .cmd_0(cmd_0), .sem_id_0(sem_id_0),
        .req_1(req_1), .cmd_1(cmd_1), .sem_id_1(sem_id_1),
        .resp_vld_0(resp_vld_0), .resp_ok_0(resp_ok_0), .semerr_0(semerr_0), .notify_0(notify_0),
        .resp_vld_1(resp_vld_1), .resp_ok_1(resp_ok_1), .semerr_1(semerr_1), .notify_1(notify_1),
        .lock_stat(lock_stat), .owner_stat(owner_stat)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request pair for a single edge, then sample just after it.
    task automatic step(input logic r0, input logic c0, input logic [3:0] i0,
                        input logic r1, input logic c1, input logic [3:0] i1);
        req_0 = r0; cmd_0 = c0; sem_id_0 = i0;
        req_1 = r1; cmd_1 = c1; sem_id_1 = i1;
        @(posedge hclk);
        #1;
        req_0 = 1'b0;
        req_1 = 1'b0;
    endtask

    task automatic idle();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset = 1'b1;
        req_0 = 0; cmd_0 = 0; sem_id_0 = 0;
        req_1 = 0; cmd_1 = 0; sem_id_1 = 0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_lock_stat", 32'(lock_stat), 32'h0);
        chk("rst_owner_stat", 32'(owner_stat), 32'h0);
        chk("rst_vld0", 32'(resp_vld_0), 32'h0);
        chk("rst_semerr1", semerr_1, 32'h0);
        hreset = 1'b0;
        idle();

        // Basic lock, busy, unlock with notify.
        step(1, 1, 4'd3, 0, 0, 4'd0);
        chk("lk3_vld0", 32'(resp_vld_0), 32'h1);
        chk("lk3_ok0", 32'(resp_ok_0), 32'h1);
        chk("lk3_err0", semerr_0, 32'h0);
        chk("lk3_vld1", 32'(resp_vld_1), 32'h0);
        chk("lk3_lock_stat", 32'(lock_stat), 32'h08);
        chk("lk3_owner_stat", 32'(owner_stat), 32'h00);
        step(0, 0, 4'd0, 1, 1, 4'd3);
        chk("busy3_vld1", 32'(resp_vld_1), 32'h1);
        chk("busy3_ok1", 32'(resp_ok_1), 32'h0);
        chk("busy3_err1", semerr_1, 32'h0);
        step(1, 0, 4'd3, 0, 0, 4'd0);
        chk("ul3_ok0", 32'(resp_ok_0), 32'h1);
        chk("ul3_notify1", 32'(notify_1), 32'h1);
        chk("ul3_notify0", 32'(notify_0), 32'h0);
        chk("ul3_lock_stat", 32'(lock_stat), 32'h00);
        idle();
        chk("idle_vld0", 32'(resp_vld_0), 32'h0);
        chk("idle_notify1", 32'(notify_1), 32'h0);

        // Round-robin contention on id 5.
        step(1, 1, 4'd5, 1, 1, 4'd5);
        chk("rr1_ok0", 32'(resp_ok_0), 32'h1);
        chk("rr1_ok1", 32'(resp_ok_1), 32'h0);
        chk("rr1_lock_stat", 32'(lock_stat), 32'h20);
        chk("rr1_owner_stat", 32'(owner_stat), 32'h00);
        step(1, 0, 4'd5, 0, 0, 4'd0);
        chk("rr1_ul_notify1", 32'(notify_1), 32'h1);
        step(1, 1, 4'd5, 1, 1, 4'd5);
        chk("rr2_ok0", 32'(resp_ok_0), 32'h0);
        chk("rr2_ok1", 32'(resp_ok_1), 32'h1);
        chk("rr2_owner_stat", 32'(owner_stat), 32'h20);
        step(0, 0, 4'd0, 1, 0, 4'd5);
        chk("rr2_ul_ok1", 32'(resp_ok_1), 32'h1);
        chk("rr2_ul_notify0", 32'(notify_0), 32'h1);
        chk("rr2_ul_lock_stat", 32'(lock_stat), 32'h00);

        // Error codes.
        step(1, 1, 4'd3, 0, 0, 4'd0);
        chk("relk3_ok0", 32'(resp_ok_0), 32'h1);
        step(1, 1, 4'd9, 1, 0, 4'd2);
        chk("range_err0", semerr_0, 32'h8);
        chk("range_ok0", 32'(resp_ok_0), 32'h0);
        chk("free_err1", semerr_1, 32'h2);
        chk("free_ok1", 32'(resp_ok_1), 32'h0);
        step(0, 0, 4'd0, 1, 0, 4'd3);
        chk("other_err1", semerr_1, 32'h4);
        step(1, 1, 4'd3, 0, 0, 4'd0);
        chk("own_err0", semerr_0, 32'h1);
        chk("own_ok0", 32'(resp_ok_0), 32'h0);
        chk("own_lock_stat", 32'(lock_stat), 32'h08);
        idle();
        chk("idle_err0", semerr_0, 32'h0);

        // Unlock by owner while the other core locks the same id.
        step(1, 0, 4'd3, 1, 1, 4'd3);
        chk("race_ok0", 32'(resp_ok_0), 32'h1);
        chk("race_ok1", 32'(resp_ok_1), 32'h0);
        chk("race_err1", semerr_1, 32'h0);
        chk("race_notify1", 32'(notify_1), 32'h1);
        chk("race_lock_stat", 32'(lock_stat), 32'h00);
        step(1, 1, 4'd3, 0, 0, 4'd0);
        step(1, 0, 4'd3, 0, 0, 4'd0);
        chk("race_pend_cleared", 32'(notify_1), 32'h0);

        // Independent parallel requests.
        step(1, 1, 4'd1, 1, 1, 4'd6);
        chk("par_ok0", 32'(resp_ok_0), 32'h1);
        chk("par_ok1", 32'(resp_ok_1), 32'h1);
        chk("par_lock_stat", 32'(lock_stat), 32'h42);
        chk("par_owner_stat", 32'(owner_stat), 32'h40);
        step(1, 0, 4'd1, 1, 0, 4'd6);
        chk("par_ul_lock_stat", 32'(lock_stat), 32'h00);

        // Fill from core 1, then reset with a response in flight.
        for (int i = 0; i < 7; i++) step(0, 0, 4'd0, 1, 1, 4'(i));
        chk("fill_lock_stat", 32'(lock_stat), 32'h7F);
        chk("fill_owner_stat", 32'(owner_stat), 32'h7F);
        req_1 = 1'b1; cmd_1 = 1'b1; sem_id_1 = 4'd7;
        @(posedge hclk);
        #1;
        req_1 = 1'b0;
        hreset = 1'b1;
        #1;
        chk("mid_rst_vld1", 32'(resp_vld_1), 32'h0);
        chk("mid_rst_lock_stat", 32'(lock_stat), 32'h00);
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_vld", {30'h0, resp_vld_1, resp_vld_0}, 32'h0);
            chk("post_rst_notify", {30'h0, notify_1, notify_0}, 32'h0);
        end
        chk("post_rst_owner_stat", 32'(owner_stat), 32'h00);
        step(1, 1, 4'd0, 0, 0, 4'd0);
        chk("post_rst_lk0_ok0", 32'(resp_ok_0), 32'h1);
        chk("post_rst_lk0_lock_stat", 32'(lock_stat), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsem_lock.md
HSEM_LOCK -- requirements
Module: hsem_lock

Interface
REQ-001 SHALL have parameter SEM_NUM, default 8, number of hardware semaphores (1..15).
REQ-002 SHALL have parameter ID_W, default 4, width of the semaphore index field.
REQ-003 SHALL have port hclk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port hreset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have ports req_0 / req_1, input, 1, request strobe from core 0 / core 1.
REQ-006 SHALL have ports cmd_0 / cmd_1, input, 1, 1 = lock, 0 = unlock.
REQ-007 SHALL have ports sem_id_0 / sem_id_1, input, ID_W, target semaphore index.
REQ-008 SHALL have ports resp_vld_0 / resp_vld_1, output, 1, one-cycle response strobe.
REQ-009 SHALL have ports resp_ok_0 / resp_ok_1, output, 1, 1 = lock granted or unlock accepted.
REQ-010 SHALL have ports semerr_0 / semerr_1, output, 32, error code for the core, feeds the interrupt/error block.
REQ-011 SHALL have ports notify_0 / notify_1, output, 1, one-cycle pulse: semaphore this core waited on was released.
REQ-012 SHALL have port lock_stat, output, SEM_NUM, bit n = semaphore n locked.
REQ-013 SHALL have port owner_stat, output, SEM_NUM, bit n = owning core of semaphore n (0/1), 0 when free.

Function
REQ-014 SHALL hold per semaphore: locked bit, owner bit, pending_0 bit, pending_1 bit.
REQ-015 SHALL sample requests on the hclk edge where req_x=1 and drive resp_vld_x, resp_ok_x, semerr_x, notify_x registered on the following cycle (latency 1); each is high exactly one cycle.
REQ-016 SHALL evaluate all requests against semaphore state as it was at the start of the sampling cycle.
REQ-017 Lock of free, valid semaphore: set locked, owner = requester, resp_ok = 1, semerr = 0.
REQ-018 Lock of semaphore owned by the other core: resp_ok = 0, semerr = 0 (busy, not an error), set requester's pending bit.
REQ-019 Lock of semaphore already owned by requester: resp_ok = 0, semerr = 32'h1, state unchanged.
REQ-020 Unlock of semaphore owned by requester: clear locked and owner, resp_ok = 1; if the other core's pending bit is set, clear it and pulse that core's notify in the same cycle as the response.
REQ-021 Unlock of free semaphore: resp_ok = 0, semerr = 32'h2.
REQ-022 Unlock of semaphore owned by the other core: resp_ok = 0, semerr = 32'h4, state unchanged.
REQ-023 sem_id >= SEM_NUM: resp_ok = 0, semerr = 32'h8, no state change, other core's request unaffected.
REQ-024 semerr_x SHALL be 0 whenever resp_vld_x = 0.
REQ-025 Both cores lock the same free semaphore in one cycle: winner per round-robin bit rr (0 = core 0 wins); winner per REQ-017, loser per REQ-018; rr toggles only after such contention.
REQ-026 Core x unlocks semaphore n (valid) while core y locks n in the same cycle: core y gets busy per REQ-018 with pending set, then the release clears it and notify_y pulses with the responses.
REQ-027 Requests to different semaphores in one cycle SHALL be processed independently and fully in parallel.
REQ-028 A successful lock by core x SHALL clear core x's pending bit for that semaphore.
REQ-029 lock_stat and owner_stat SHALL be registered, reflecting state after the last update.

Reset
REQ-030 While hreset = 1: all locked, owner, pending bits = 0, rr = 0, all resp_vld, resp_ok, notify = 0, semerr = 32'h0, lock_stat = owner_stat = 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight responses; no pulse appears after reset deassertion without a new request.

Verification
REQ-032 Core 0 lock id 3 -> next cycle resp_vld_0=1, resp_ok_0=1, lock_stat=8'h08, owner_stat=8'h00; core 1 lock id 3 -> resp_ok_1=0, semerr_1=0.
REQ-033 Continue: core 0 unlock id 3 -> resp_ok_0=1, notify_1=1 same cycle, lock_stat=8'h00.
REQ-034 Both cores lock id 5 same cycle twice (unlocking between) -> first grant core 0, second grant core 1; owner_stat bit 5 = 0 then 1.
REQ-035 Core 1 unlock free id 2 -> semerr_1=32'h2; core 0 lock id 9 -> semerr_0=32'h8; core 1 unlock id 3 held by core 0 -> semerr_1=32'h4; core 0 re-lock own id 3 -> semerr_0=32'h1.
REQ-036 Lock ids 0..7 from core 1, assert hreset for one cycle -> lock_stat=0, no resp_vld after release.
